// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR datapath arithmetic blocks.
//   - default operand / result widths
//   - per-stage sideband record carried next to the pipeline data
//   - saturation bound helpers (signed and unsigned ranges of a given width)
//   - parameter legality check used at elaboration time by the multiplier
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_DATA_WIDTH   = 16;
   localparam int FIR_RESULT_WIDTH = 32;

   // Width of the internal comparison domain used for saturation. It must be
   // strictly wider than the widest rounded product (2*64 + 1 guard bit) so
   // that both signed and unsigned values can be compared as signed numbers.
   localparam int SAT_W = 130;

   // Operand signedness as carried with each sample.
   typedef enum logic {
      MODE_UNSIGNED = 1'b0,
      MODE_SIGNED   = 1'b1
   } mult_mode_e;

   // Control bits that travel with a sample through the early stages.
   typedef struct packed {
      logic valid;
      logic neg;          // product must be negated after the magnitude multiply
      logic signed_mode;  // 1 = two's-complement operands
   } stage_ctrl_t;

   // Largest representable value of an rw-bit result.
   function automatic logic signed [SAT_W-1:0] sat_hi(input int rw, input logic is_signed);
      logic signed [SAT_W-1:0] one;
      one = 1;
      return is_signed ? (one <<< (rw - 1)) - one : (one <<< rw) - one;
   endfunction

   // Smallest representable value of an rw-bit result.
   function automatic logic signed [SAT_W-1:0] sat_lo(input int rw, input logic is_signed);
      logic signed [SAT_W-1:0] one;
      one = 1;
      return is_signed ? -(one <<< (rw - 1)) : '0;
   endfunction

   // Legal parameter combinations for the pipelined multiplier.
   function automatic bit params_ok(input int dw, input int rw, input int fs);
      return (dw % 2 == 0) && (dw >= 4) && (dw <= 64) &&
             (rw >= 1) && (rw <= 2 * dw) &&
             (fs >= 0) && (fs < 2 * dw);
   endfunction

endpackage

// File: rtl/mult_output_conditioner.sv
// -----------------------------------------------------------------------------
// mult_output_conditioner
// Combinational round / shift / saturate stage for a full-width product.
// Also usable on the accumulator output, so it keeps the multiplier's
// parameter set.
//
// Ports
//   product      in   2*DATA_WIDTH  full product (two's complement when signed)
//   signed_mode  in   1             1 = product is signed, 0 = unsigned
//   result       out  RESULT_WIDTH  conditioned result
//   sat_flag     out  1             result was clamped to its range
// -----------------------------------------------------------------------------
module mult_output_conditioner
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
   parameter int RESULT_WIDTH = FIR_RESULT_WIDTH,
   parameter int FRAC_SHIFT   = 0,
   parameter int ROUND_EN     = 1,
   parameter int SAT_EN       = 1
) (
   input  logic [2*DATA_WIDTH-1:0] product,
   input  logic                    signed_mode,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    sat_flag
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int EW = PW + 1;   // one guard bit so the rounding add never wraps

   // Half-LSB of the shifted result; zero when rounding is off or no shift.
   localparam logic [EW-1:0] ROUND_K =
      (ROUND_EN != 0 && FRAC_SHIFT > 0) ? (EW'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0))
                                        : '0;

   logic [EW-1:0]           ext;
   logic [EW-1:0]           rnd_sum;
   logic [EW-1:0]           shifted;
   logic signed [SAT_W-1:0] wide;
   logic signed [SAT_W-1:0] lim_hi;
   logic signed [SAT_W-1:0] lim_lo;

   always_comb begin
      ext     = signed_mode ? {product[PW-1], product} : {1'b0, product};
      rnd_sum = ext + ROUND_K;

      // Adding half an LSB then flooring gives round-half-toward-+infinity
      // for both signs, so negative ties are not special-cased.
      if (signed_mode) begin
         shifted = $signed(rnd_sum) >>> FRAC_SHIFT;
      end else begin
         shifted = rnd_sum >> FRAC_SHIFT;
      end

      // Bring both interpretations into one signed domain for the clamp.
      wide = signed_mode ? {{(SAT_W-EW){shifted[EW-1]}}, shifted}
                         : {{(SAT_W-EW){1'b0}}, shifted};

      lim_hi = sat_hi(RESULT_WIDTH, signed_mode);
      lim_lo = sat_lo(RESULT_WIDTH, signed_mode);

      result   = wide[RESULT_WIDTH-1:0];
      sat_flag = 1'b0;
      if (SAT_EN != 0) begin
         if (wide > lim_hi) begin
            result   = lim_hi[RESULT_WIDTH-1:0];
            sat_flag = 1'b1;
         end else if (wide < lim_lo) begin
            result   = lim_lo[RESULT_WIDTH-1:0];
            sat_flag = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier
// Four-stage integer multiplier for the FIR datapath with valid/ready flow
// control, per-sample signed/unsigned operands and an optional fixed-point
// output stage (round, shift, saturate).
//
//   S1  operand magnitudes + result sign
//   S2  four HALF x HALF partial products
//   S3  recombined product, sign restored
//   S4  conditioned result (round / shift / saturate)
//
// All stages advance together on en = !out_valid || out_ready; a stalled
// output freezes the whole pipe, so nothing can be lost or duplicated.
//
// Ports
//   clk          in   1             system clock
//   rst_n        in   1             asynchronous active-low reset
//   in_valid     in   1             operands valid
//   in_ready     out  1             operands accepted this cycle
//   a_in, b_in   in   DATA_WIDTH    operands
//   signed_mode  in   1             1 = two's complement, 0 = unsigned
//   out_valid    out  1             result valid
//   out_ready    in   1             downstream accepts result
//   result       out  RESULT_WIDTH  conditioned product
//   sat_flag     out  1             result was clipped (with out_valid)
// -----------------------------------------------------------------------------
module pipelined_multiplier
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
   parameter int RESULT_WIDTH = FIR_RESULT_WIDTH,
   parameter int FRAC_SHIFT   = 0,
   parameter int ROUND_EN     = 1,
   parameter int SAT_EN       = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   a_in,
   input  logic [DATA_WIDTH-1:0]   b_in,
   input  logic                    signed_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    sat_flag
);

   localparam int HALF = DATA_WIDTH / 2;
   localparam int PW   = 2 * DATA_WIDTH;

   generate
      if (!params_ok(DATA_WIDTH, RESULT_WIDTH, FRAC_SHIFT)) begin : g_bad_params
         $error("pipelined_multiplier: illegal DATA_WIDTH/RESULT_WIDTH/FRAC_SHIFT combination");
      end
   endgenerate

   // ---------------------------------------------------------------- control
   logic en;
   logic out_valid_reg;

   assign en       = !out_valid_reg || out_ready;
   assign in_ready = en;

   // ---------------------------------------------------------------- S1
   stage_ctrl_t           s1_ctrl_reg;
   stage_ctrl_t           s1_ctrl_next;
   logic [DATA_WIDTH-1:0] mag_a_reg;
   logic [DATA_WIDTH-1:0] mag_a_next;
   logic [DATA_WIDTH-1:0] mag_b_reg;
   logic [DATA_WIDTH-1:0] mag_b_next;

   // Negating the most negative operand wraps back to itself, which is the
   // correct magnitude 2^(DATA_WIDTH-1) when read as unsigned.
   always_comb begin
      s1_ctrl_next.valid       = in_valid;
      s1_ctrl_next.signed_mode = signed_mode;
      if (signed_mode == MODE_SIGNED) begin
         mag_a_next        = a_in[DATA_WIDTH-1] ? -a_in : a_in;
         mag_b_next        = b_in[DATA_WIDTH-1] ? -b_in : b_in;
         s1_ctrl_next.neg  = a_in[DATA_WIDTH-1] ^ b_in[DATA_WIDTH-1];
      end else begin
         mag_a_next        = a_in;
         mag_b_next        = b_in;
         s1_ctrl_next.neg  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ctrl_reg <= '0;
         mag_a_reg   <= '0;
         mag_b_reg   <= '0;
      end else if (en) begin
         s1_ctrl_reg <= s1_ctrl_next;
         mag_a_reg   <= mag_a_next;
         mag_b_reg   <= mag_b_next;
      end
   end

   // ---------------------------------------------------------------- S2
   // Partial product index gi: bit 0 selects the half of A, bit 1 the half
   // of B.  0 = lo*lo, 1 = hi(A)*lo(B), 2 = lo(A)*hi(B), 3 = hi*hi.
   stage_ctrl_t           s2_ctrl_reg;
   logic [DATA_WIDTH-1:0] pp_next [4];
   logic [DATA_WIDTH-1:0] pp_reg  [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pp
         logic [HALF-1:0] op_a;
         logic [HALF-1:0] op_b;
         assign op_a        = (gi % 2 == 1) ? mag_a_reg[DATA_WIDTH-1:HALF] : mag_a_reg[HALF-1:0];
         assign op_b        = (gi / 2 == 1) ? mag_b_reg[DATA_WIDTH-1:HALF] : mag_b_reg[HALF-1:0];
         assign pp_next[gi] = DATA_WIDTH'(op_a) * DATA_WIDTH'(op_b);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_ctrl_reg <= '0;
         for (int i = 0; i < 4; i++) begin
            pp_reg[i] <= '0;
         end
      end else if (en) begin
         s2_ctrl_reg <= s1_ctrl_reg;
         for (int i = 0; i < 4; i++) begin
            pp_reg[i] <= pp_next[i];
         end
      end
   end

   // ---------------------------------------------------------------- S3
   logic          s3_valid_reg;
   logic          s3_mode_reg;
   logic [PW-1:0] mag_full;
   logic [PW-1:0] p_next;
   logic [PW-1:0] p_reg;

   // Everything is widened to PW before adding so cross-term carries are kept.
   always_comb begin
      mag_full = (PW'(pp_reg[3]) << DATA_WIDTH)
               + ((PW'(pp_reg[1]) + PW'(pp_reg[2])) << HALF)
               + PW'(pp_reg[0]);
      p_next   = s2_ctrl_reg.neg ? -mag_full : mag_full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_reg <= 1'b0;
         s3_mode_reg  <= 1'b0;
         p_reg        <= '0;
      end else if (en) begin
         s3_valid_reg <= s2_ctrl_reg.valid;
         s3_mode_reg  <= s2_ctrl_reg.signed_mode;
         p_reg        <= p_next;
      end
   end

   // ---------------------------------------------------------------- S4
   logic [RESULT_WIDTH-1:0] cond_result;
   logic                    cond_sat;
   logic [RESULT_WIDTH-1:0] result_reg;
   logic                    sat_flag_reg;

   mult_output_conditioner #(
      .DATA_WIDTH   (DATA_WIDTH),
      .RESULT_WIDTH (RESULT_WIDTH),
      .FRAC_SHIFT   (FRAC_SHIFT),
      .ROUND_EN     (ROUND_EN),
      .SAT_EN       (SAT_EN)
   ) u_cond (
      .product     (p_reg),
      .signed_mode (s3_mode_reg),
      .result      (cond_result),
      .sat_flag    (cond_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         sat_flag_reg  <= 1'b0;
      end else if (en) begin
         out_valid_reg <= s3_valid_reg;
         result_reg    <= cond_result;
         sat_flag_reg  <= cond_sat;
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign sat_flag  = sat_flag_reg;

endmodule
